// File: rtl/dmem_pkg.sv
// Shared definitions for the latency-configurable data memory: funct3 encodings,
// FSM state type and data width.
package dmem_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering for loads and stores, plus illegal-access detection.
// Alignment errors are flagged only when DMEM_LAT_MISALIGN_CHK_EN is defined.
module dmem_lane
   import dmem_pkg::*;
(
   input  logic            we,
   input  logic [2:0]      funct3,
   input  logic [1:0]      lane,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rword,
   output logic [XLEN-1:0] wdata_sh,
   output logic [3:0]      be,
   output logic [XLEN-1:0] rdata,
   output logic            illegal
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rword[{lane, 3'b000} +: 8];
   assign half_sel = lane[1] ? rword[31:16] : rword[15:0];

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      wdata_sh = '0;
      be       = '0;
      rdata    = '0;
      illegal  = 1'b0;
      if (we) begin
         // Data is replicated across lanes; the byte enables pick the live copy.
         unique case (funct3)
            F3_B: begin
               be       = 4'b0001 << lane;
               wdata_sh = {4{wdata[7:0]}};
            end
            F3_H: begin
               be       = lane[1] ? 4'b1100 : 4'b0011;
               wdata_sh = {2{wdata[15:0]}};
            end
            F3_W: begin
               be       = 4'b1111;
               wdata_sh = wdata;
            end
            default: illegal = 1'b1;
         endcase
      end else begin
         unique case (funct3)
            F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata = {24'h0, byte_sel};
            F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata = {16'h0, half_sel};
            F3_W:    rdata = rword;
            default: illegal = 1'b1;
         endcase
      end
`ifdef DMEM_LAT_MISALIGN_CHK_EN
      if ((funct3 == F3_H || funct3 == F3_HU) && lane[0])
         illegal = 1'b1;
      if (funct3 == F3_W && lane != 2'b00)
         illegal = 1'b1;
`endif
   end

endmodule

// File: rtl/dmem_lat.sv
// Data memory with byte/half/word access and fixed LATENCY behind a valid/ready
// request and a one-cycle response pulse. Optional: DMEM_LAT_MISALIGN_CHK_EN.
module dmem_lat
   import dmem_pkg::*;
#(
   parameter  int DEPTH   = 1024,
   parameter  int LATENCY = 2,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [2:0]      req_funct3,
   input  logic [31:0]     req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            rsp_valid,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err
);

   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            cap_we;
   logic [2:0]      cap_f3;
   logic [31:0]     cap_addr;
   logic [XLEN-1:0] cap_wdata;

   logic [XLEN-1:0] mem [DEPTH];

   logic [AW-1:0]   word_idx;
   logic            out_of_range;
   logic [XLEN-1:0] rword;
   logic [XLEN-1:0] wdata_sh;
   logic [3:0]      be;
   logic [XLEN-1:0] lane_rdata;
   logic            illegal;
   logic            err;
   logic            access;

   assign word_idx     = cap_addr[AW+1:2];
   assign out_of_range = |cap_addr[31:AW+2];
   assign rword        = mem[word_idx];
   assign err          = out_of_range | illegal;
   assign access       = (state == WAIT) && (cnt == '0);
   assign req_ready    = (state == IDLE);

   dmem_lane u_lane (
      .we       (cap_we),
      .funct3   (cap_f3),
      .lane     (cap_addr[1:0]),
      .wdata    (cap_wdata),
      .rword    (rword),
      .wdata_sh (wdata_sh),
      .be       (be),
      .rdata    (lane_rdata),
      .illegal  (illegal)
   );

   // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         cap_we    <= 1'b0;
         cap_f3    <= '0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  cap_we    <= req_we;
                  cap_f3    <= req_funct3;
                  cap_addr  <= req_addr;
                  cap_wdata <= req_wdata;
                  cnt       <= CW'(LATENCY - 1);
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= err;
                  rsp_rdata <= (err || cap_we) ? '0 : lane_rdata;
                  state     <= RESP;
               end
            end
            RESP: begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: the RAM array has no reset; a reset mid-access only suppresses the pending write.
   always_ff @(posedge clk) begin
      if (access && cap_we && !err && !reset) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b])
               mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_lat.sv
// Directed bench for dmem_lat (DEPTH=1024, LATENCY=2): cycle-exact handshake
// sequence, a vector table of loads/stores, reset mid-access and alignment case.
module tb_dmem_lat;
   import dmem_pkg::*;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   dmem_lat #(.DEPTH(1024), .LATENCY(LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", name, act, exp);
      else
         n_pass++;
   endtask

   // Issues one request and waits (bounded) for its response pulse.
   task automatic transact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rd,
                           output logic er, output int lat, output bit got);
      got = 0; rd = '0; er = 1'b0; lat = 0;
      @(negedge clk);
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
      @(posedge clk); #1;
      // Scramble inputs after acceptance; the captured request must be unaffected.
      req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555; req_funct3 = 3'b111;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) begin
            rd = rsp_rdata; er = rsp_err; lat = i; got = 1;
            break;
         end
      end
   endtask

   vec_t        vecs[$];
   logic [31:0] rd;
   logic        er;
   int          lat;
   bit          got;

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
      req_addr = '0; req_wdata = '0;
      #12;
      check("reset_ready", 32'(req_ready), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_rdata", rsp_rdata, 32'h0);
      check("reset_rsp_err", 32'(rsp_err), 32'd0);
      @(negedge clk); reset = 1'b0;

      // Cycle-exact SW 0xDEADBEEF @0x10, accepted at edge 0.
      @(negedge clk);
      req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
      @(posedge clk); #1; req_valid = 1'b0; req_wdata = 32'h0;
      check("e0_ready", 32'(req_ready), 32'd0);
      check("e0_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      check("e1_ready", 32'(req_ready), 32'd0);
      check("e1_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      check("e2_ready", 32'(req_ready), 32'd0);
      check("e2_valid", 32'(rsp_valid), 32'd1);
      check("e2_err", 32'(rsp_err), 32'd0);
      check("e2_rdata", rsp_rdata, 32'h0);
      @(posedge clk); #1;
      check("e3_ready", 32'(req_ready), 32'd1);
      check("e3_valid", 32'(rsp_valid), 32'd0);

      vecs.push_back('{"lw_10",      1'b0, F3_W,   32'h10,   32'h0,         32'hDEAD_BEEF, 1'b0});
      vecs.push_back('{"sb_12",      1'b1, F3_B,   32'h12,   32'hFFFF_FF7F, 32'h0,         1'b0});
      vecs.push_back('{"lw_10_sb",   1'b0, F3_W,   32'h10,   32'h0,         32'hDE7F_BEEF, 1'b0});
      vecs.push_back('{"lb_11",      1'b0, F3_B,   32'h11,   32'h0,         32'hFFFF_FFBE, 1'b0});
      vecs.push_back('{"lbu_11",     1'b0, F3_BU,  32'h11,   32'h0,         32'h0000_00BE, 1'b0});
      vecs.push_back('{"lh_12",      1'b0, F3_H,   32'h12,   32'h0,         32'hFFFF_DE7F, 1'b0});
      vecs.push_back('{"lhu_10",     1'b0, F3_HU,  32'h10,   32'h0,         32'h0000_BEEF, 1'b0});
      vecs.push_back('{"sw_0",       1'b1, F3_W,   32'h0,    32'hA5A5_A5A5, 32'h0,         1'b0});
      vecs.push_back('{"lw_oor",     1'b0, F3_W,   32'h1000, 32'h0,         32'h0,         1'b1});
      vecs.push_back('{"sw_oor",     1'b1, F3_W,   32'h1000, 32'h1111_1111, 32'h0,         1'b1});
      vecs.push_back('{"lw_0_a",     1'b0, F3_W,   32'h0,    32'h0,         32'hA5A5_A5A5, 1'b0});
      vecs.push_back('{"ld_f3_011",  1'b0, 3'b011, 32'h0,    32'h0,         32'h0,         1'b1});
      vecs.push_back('{"st_f3_100",  1'b1, 3'b100, 32'h0,    32'h0,         32'h0,         1'b1});
      vecs.push_back('{"lw_0_b",     1'b0, F3_W,   32'h0,    32'h0,         32'hA5A5_A5A5, 1'b0});
      vecs.push_back('{"sw_14",      1'b1, F3_W,   32'h14,   32'h0,         32'h0,         1'b0});
      vecs.push_back('{"sh_16",      1'b1, F3_H,   32'h16,   32'hABCD_8001, 32'h0,         1'b0});
      vecs.push_back('{"lw_14",      1'b0, F3_W,   32'h14,   32'h0,         32'h8001_0000, 1'b0});
      vecs.push_back('{"lh_16",      1'b0, F3_H,   32'h16,   32'h0,         32'hFFFF_8001, 1'b0});
      vecs.push_back('{"lbu_17",     1'b0, F3_BU,  32'h17,   32'h0,         32'h0000_0080, 1'b0});
      vecs.push_back('{"sw_20",      1'b1, F3_W,   32'h20,   32'hCAFE_F00D, 32'h0,         1'b0});

      foreach (vecs[i]) begin
         transact(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat, got);
         check({vecs[i].name, "_got"}, 32'(got), 32'd1);
         check({vecs[i].name, "_lat"}, 32'(lat), 32'(LAT));
         check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
         check({vecs[i].name, "_err"}, 32'(er), 32'(vecs[i].exp_err));
      end

      // Reset during WAIT of SW 0x12345678 @0x20: store must be dropped.
      @(negedge clk);
      req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h20; req_wdata = 32'h1234_5678; req_valid = 1'b1;
      @(posedge clk); #1; req_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1; #1;
      check("rst_mid_ready", 32'(req_ready), 32'd1);
      check("rst_mid_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      check("rst_hold_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk); reset = 1'b0;
      transact(1'b0, F3_W, 32'h20, 32'h0, rd, er, lat, got);
      check("rst_lw_got", 32'(got), 32'd1);
      check("rst_lw_rdata", rd, 32'hCAFE_F00D);
      check("rst_lw_err", 32'(er), 32'd0);

      // Misaligned word load.
      transact(1'b0, F3_W, 32'h22, 32'h0, rd, er, lat, got);
      check("mis_lw_got", 32'(got), 32'd1);
`ifdef DMEM_LAT_MISALIGN_CHK_EN
      check("mis_lw_err", 32'(er), 32'd1);
      check("mis_lw_rdata", rd, 32'h0);
`else
      check("mis_lw_err", 32'(er), 32'd0);
      check("mis_lw_rdata", rd, 32'hCAFE_F00D);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
